// File: rtl/key_mode_sel_pkg.sv
// Shared types and defaults for the key-driven mode selector.
// Holds the debounce FSM encoding and the wrap helpers for the mode code.
package key_mode_sel_pkg;

    localparam int DEF_DEBOUNCE_CNT   = 1000000;
    localparam int DEF_LONG_PRESS_CNT = 50000000;
    localparam int DEF_MODE_MAX       = 5;
    localparam int SW_W               = 4;

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_PRESS_CHK = 2'd1,
        DB_HELD      = 2'd2,
        DB_REL_CHK   = 2'd3
    } db_state_e;

    function automatic logic [SW_W-1:0] mode_inc(input logic [SW_W-1:0] v,
                                                  input logic [SW_W-1:0] max);
        return (v >= max) ? '0 : v + SW_W'(1);
    endfunction

    function automatic logic [SW_W-1:0] mode_dec(input logic [SW_W-1:0] v,
                                                  input logic [SW_W-1:0] max);
        return ((v == '0) || (v > max)) ? max : v - SW_W'(1);
    endfunction

endpackage

// File: rtl/key_mode_sel_debounce.sv
// Two-flop synchronizer plus debounce FSM for one active-low push button.
// Emits a debounced level and single-cycle press/release pulses.
module key_debounce
    import key_mode_sel_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key_n_i,
    output logic      lvl_o,
    output logic      press_o,
    output logic      release_o,
    output db_state_e state_o
);

    localparam int             CW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [1:0]    sync_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          press_q;
    logic          release_q;
    logic          pressed;

    // sync_q[1] is the only copy of the raw key the FSM ever looks at.
    assign pressed = ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= DB_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                DB_IDLE: begin
                    if (pressed) begin
                        if (DEBOUNCE_CNT <= 1) begin
                            state_q <= DB_HELD;
                            press_q <= 1'b1;
                        end else begin
                            state_q <= DB_PRESS_CHK;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                DB_PRESS_CHK: begin
                    if (!pressed) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q <= DB_HELD;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DB_HELD: begin
                    if (!pressed) begin
                        if (DEBOUNCE_CNT <= 1) begin
                            state_q   <= DB_IDLE;
                            release_q <= 1'b1;
                        end else begin
                            state_q <= DB_REL_CHK;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                DB_REL_CHK: begin
                    if (pressed) begin
                        state_q <= DB_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q   <= DB_IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= DB_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign lvl_o     = (state_q == DB_HELD) || (state_q == DB_REL_CHK);
    assign press_o   = press_q;
    assign release_o = release_q;
    assign state_o   = state_q;

endmodule

// File: rtl/key_mode_sel.sv
// Mode selector: next/prev buttons step a wrapping mode code, a long hold on
// next forces mode 0. Both buttons are debounced by key_debounce instances.
module key_mode_sel
    import key_mode_sel_pkg::*;
#(
    parameter int DEBOUNCE_CNT   = DEF_DEBOUNCE_CNT,
    parameter int LONG_PRESS_CNT = DEF_LONG_PRESS_CNT,
    parameter int MODE_MAX       = DEF_MODE_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_next_n,
    input  logic            key_prev_n,
    output logic [SW_W-1:0] sw_o,
    output logic            mode_chg,
    output logic [1:0]      key_lvl,
    output db_state_e       dbg_next_state_o,
    output db_state_e       dbg_prev_state_o
);

    localparam int               HW        = $clog2(LONG_PRESS_CNT + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(LONG_PRESS_CNT - 1);
    localparam logic [HW-1:0]    HOLD_MAX  = HW'(LONG_PRESS_CNT);
    localparam logic [SW_W-1:0]  MAX_CODE  = SW_W'(MODE_MAX);

    logic next_press, next_rel, prev_press, prev_rel;
    logic unused_pulses;

    logic [SW_W-1:0] sw_q, sw_d;
    logic            mode_chg_q, mode_chg_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            long_q, long_d;
    logic            long_hit, next_evt, prev_evt;

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_next (
        .clk       (clk),
        .rst       (rst),
        .key_n_i   (key_next_n),
        .lvl_o     (key_lvl[0]),
        .press_o   (next_press),
        .release_o (next_rel),
        .state_o   (dbg_next_state_o)
    );

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_prev (
        .clk       (clk),
        .rst       (rst),
        .key_n_i   (key_prev_n),
        .lvl_o     (key_lvl[1]),
        .press_o   (prev_press),
        .release_o (prev_rel),
        .state_o   (dbg_prev_state_o)
    );

    assign unused_pulses = ^{next_press, prev_rel};

    // The long flag is cleared when the release pulse is consumed, so that
    // the same pulse still sees it and skips the increment.
    always_comb begin
        hold_d   = hold_q;
        long_d   = long_q;
        sw_d     = sw_q;
        long_hit = key_lvl[0] && (hold_q == HOLD_LAST);
        next_evt = next_rel && !long_q;
        prev_evt = prev_press;

        if (!key_lvl[0]) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
        end

        if (long_hit) begin
            sw_d   = '0;
            long_d = 1'b1;
        end else begin
            if (next_rel) begin
                long_d = 1'b0;
            end
            if (next_evt && !prev_evt) begin
                sw_d = mode_inc(sw_q, MAX_CODE);
            end else if (prev_evt && !next_evt) begin
                sw_d = mode_dec(sw_q, MAX_CODE);
            end
        end

        mode_chg_d = (sw_d != sw_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q       <= '0;
            mode_chg_q <= 1'b0;
            hold_q     <= '0;
            long_q     <= 1'b0;
        end else begin
            sw_q       <= sw_d;
            mode_chg_q <= mode_chg_d;
            hold_q     <= hold_d;
            long_q     <= long_d;
        end
    end

    assign sw_o     = sw_q;
    assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_key_mode_sel.sv
// Bench for key_mode_sel: directed scenarios plus random key waveforms,
// scored against a history-window model of debounce and mode stepping.
module tb_key_mode_sel;
    import key_mode_sel_pkg::*;

    localparam int D   = 4;
    localparam int L   = 20;
    localparam int MAX = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_next_n = 1'b1;
    logic       key_prev_n = 1'b1;
    logic [3:0] sw_o;
    logic       mode_chg;
    logic [1:0] key_lvl;
    db_state_e  dbg_next_state, dbg_prev_state;

    int tests = 0;
    int fails = 0;
    int chg_seen = 0;
    bit lvl0_seen = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    key_mode_sel #(.DEBOUNCE_CNT(D), .LONG_PRESS_CNT(L), .MODE_MAX(MAX)) dut (
        .clk              (clk),
        .rst              (rst),
        .key_next_n       (key_next_n),
        .key_prev_n       (key_prev_n),
        .sw_o             (sw_o),
        .mode_chg         (mode_chg),
        .key_lvl          (key_lvl),
        .dbg_next_state_o (dbg_next_state),
        .dbg_prev_state_o (dbg_prev_state)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a key's level flips once the last D synchronized
    // samples all disagree with it; mode steps one cycle after the event.
    logic [3:0] m_sw = '0;
    bit         m_lvl[2];
    bit         m_long = 0;
    bit         m_chg = 0;
    int         m_held = 0;
    bit         pend_next_rel = 0;
    bit         pend_prev_press = 0;
    bit         s1[2], s2[2];
    bit         hist[2][D];

    always @(posedge clk) begin
        bit raw[2];
        bit samp, all_p, all_r, long_hit, inc, dec;
        logic [3:0] old;
        raw[0] = key_next_n;
        raw[1] = key_prev_n;
        if (rst) begin
            m_sw = '0; m_long = 0; m_chg = 0; m_held = 0;
            pend_next_rel = 0; pend_prev_press = 0;
            for (int k = 0; k < 2; k++) begin
                m_lvl[k] = 0; s1[k] = 1; s2[k] = 1;
                for (int j = 0; j < D; j++) hist[k][j] = 1;
            end
        end else begin
            old = m_sw;
            long_hit = 0;
            if (m_lvl[0]) begin
                m_held++;
                if (m_held == L) long_hit = 1;
            end else begin
                m_held = 0;
            end
            inc = pend_next_rel && !m_long;
            dec = pend_prev_press;
            if (long_hit) begin
                m_sw = 0;
                m_long = 1;
            end else begin
                if (pend_next_rel) m_long = 0;
                if (inc && !dec) m_sw = (m_sw == MAX) ? 4'd0 : m_sw + 4'd1;
                else if (dec && !inc) m_sw = (m_sw == 0) ? 4'(MAX) : m_sw - 4'd1;
            end
            m_chg = (m_sw != old);
            if (m_chg) exp_q.push_back(m_sw);

            pend_next_rel = 0;
            pend_prev_press = 0;
            for (int k = 0; k < 2; k++) begin
                samp = s2[k];
                s2[k] = s1[k];
                s1[k] = raw[k];
                for (int j = D - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = samp;
                all_p = 1; all_r = 1;
                for (int j = 0; j < D; j++) begin
                    if (hist[k][j]) all_p = 0;
                    else all_r = 0;
                end
                if (!m_lvl[k] && all_p) begin
                    m_lvl[k] = 1;
                    if (k == 1) pend_prev_press = 1;
                end else if (m_lvl[k] && all_r) begin
                    m_lvl[k] = 0;
                    if (k == 0) pend_next_rel = 1;
                end
            end
        end
    end

    // Monitor: pops an expected mode on each mode_chg and tracks levels.
    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (key_lvl[0]) lvl0_seen = 1;
        check("key_lvl", int'(key_lvl), int'({m_lvl[1], m_lvl[0]}));
        check("sw_track", int'(sw_o), int'(m_sw));
        check("mode_chg", int'(mode_chg), int'(m_chg));
        if (mode_chg) begin
            chg_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mode_chg_pop: pulse with sw_o=%0d, required no pulse", sw_o);
            end else begin
                e = exp_q.pop_front();
                check("mode_chg_sw", int'(sw_o), int'(e));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap_next(input int hold, input int gap);
        key_next_n = 1'b0;
        cyc(hold);
        key_next_n = 1'b1;
        cyc(gap);
    endtask

    task automatic tap_prev(input int hold, input int gap);
        key_prev_n = 1'b0;
        cyc(hold);
        key_prev_n = 1'b1;
        cyc(gap);
    endtask

    initial begin
        int base;
        cyc(3);
        check("reset_sw", int'(sw_o), 0);
        check("reset_mode_chg", int'(mode_chg), 0);
        check("reset_key_lvl", int'(key_lvl), 0);
        rst = 1'b0;
        cyc(2);

        // clean press 0 -> 1
        base = chg_seen;
        key_next_n = 1'b0;
        cyc(10);
        check("clean_hold_lvl", int'(key_lvl[0]), 1);
        key_next_n = 1'b1;
        cyc(15);
        check("clean_sw", int'(sw_o), 1);
        check("clean_chg_count", chg_seen - base, 1);

        // glitches shorter than D
        base = chg_seen;
        lvl0_seen = 0;
        repeat (5) begin
            key_next_n = 1'b0; cyc(2);
            key_next_n = 1'b1; cyc(2);
        end
        cyc(10);
        check("glitch_lvl_seen", int'(lvl0_seen), 0);
        check("glitch_sw", int'(sw_o), 1);
        check("glitch_chg_count", chg_seen - base, 0);

        // wrap both ways
        repeat (4) tap_next(8, 12);
        check("step_to_5", int'(sw_o), 5);
        tap_next(8, 12);
        check("wrap_up_0", int'(sw_o), 0);
        tap_prev(8, 12);
        check("wrap_down_5", int'(sw_o), 5);

        // long press from 3
        tap_prev(8, 12);
        tap_prev(8, 12);
        check("step_to_3", int'(sw_o), 3);
        base = chg_seen;
        key_next_n = 1'b0;
        cyc(30);
        check("long_sw_held", int'(sw_o), 0);
        key_next_n = 1'b1;
        cyc(15);
        check("long_sw_after_rel", int'(sw_o), 0);
        check("long_chg_count", chg_seen - base, 1);

        // simultaneous next release and prev press at 2
        tap_next(8, 12);
        tap_next(8, 12);
        check("step_to_2", int'(sw_o), 2);
        base = chg_seen;
        key_next_n = 1'b0;
        cyc(8);
        key_next_n = 1'b1;
        key_prev_n = 1'b0;
        cyc(8);
        key_prev_n = 1'b1;
        cyc(15);
        check("simul_sw", int'(sw_o), 2);
        check("simul_chg_count", chg_seen - base, 0);

        // reset mid-debounce at 4, key held through reset
        tap_next(8, 12);
        tap_next(8, 12);
        check("step_to_4", int'(sw_o), 4);
        key_next_n = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(2);
        check("rst_mid_sw", int'(sw_o), 0);
        check("rst_mid_lvl", int'(key_lvl), 0);
        check("rst_mid_chg", int'(mode_chg), 0);
        rst = 1'b0;
        cyc(3);
        check("after_rst_sw", int'(sw_o), 0);
        cyc(7);
        check("after_rst_lvl", int'(key_lvl[0]), 1);
        check("after_rst_sw_held", int'(sw_o), 0);
        key_next_n = 1'b1;
        cyc(15);
        check("after_rst_release_sw", int'(sw_o), 1);

        // random key waveforms with occasional reset
        for (int i = 0; i < 200; i++) begin
            key_next_n = 1'($urandom_range(0, 1));
            key_prev_n = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 25));
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        cyc(40);
        check("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_mode_sel.md
KEY_MODE_SEL -- requirements
Module: key_mode_sel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 1000000, meaning consecutive stable clk samples needed to accept a key level change (20 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CNT, default 50000000, meaning clk cycles of debounced hold on key_next that count as a long press.
REQ-003 SHALL have parameter MODE_MAX, default 5, meaning the highest mode code; legal range 1..15.
REQ-004 clk  input  1  system clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 key_next_n  input  1  raw push-button input, active-low, asynchronous to clk.
REQ-007 key_prev_n  input  1  raw push-button input, active-low, asynchronous to clk.
REQ-008 sw_o  output  4  registered mode code for the LED pattern block's sw input.
REQ-009 mode_chg  output  1  one-cycle pulse, high in the same cycle sw_o takes a new value.
REQ-010 key_lvl  output  2  debounced pressed levels, active-high: [1]=prev, [0]=next.

Function
REQ-011 Each raw key SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Per-key debounce FSM SHALL have states IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-013 IDLE->PRESS_CHK on synchronized pressed; PRESS_CHK->HELD after DEBOUNCE_CNT consecutive pressed samples; any released sample in PRESS_CHK SHALL return the FSM to IDLE and clear its counter.
REQ-014 HELD->REL_CHK on synchronized released; REL_CHK->IDLE after DEBOUNCE_CNT consecutive released samples; any pressed sample in REL_CHK SHALL return the FSM to HELD.
REQ-015 key_lvl bit SHALL be 1 exactly while that key's FSM is in HELD or REL_CHK.
REQ-016 Entering HELD SHALL emit a one-cycle press pulse; entering IDLE from REL_CHK SHALL emit a one-cycle release pulse.
REQ-017 Prev press pulse SHALL decrement sw_o on the next clk edge, wrapping 0 -> MODE_MAX.
REQ-018 Next release pulse SHALL increment sw_o, wrapping MODE_MAX -> 0, only if no long press was flagged during that hold.
REQ-019 A hold counter SHALL run while key_next is in HELD/REL_CHK; when it reaches LONG_PRESS_CNT it SHALL set sw_o to 0 once, set a long flag, and saturate.
REQ-020 The long flag SHALL suppress the increment at the following release and SHALL clear when key_next FSM reaches IDLE.
REQ-021 Next and prev events in the same cycle SHALL leave sw_o unchanged, with no mode_chg pulse.
REQ-022 mode_chg SHALL pulse only when the new sw_o value differs from the old (long press at mode 0 gives no pulse).
REQ-023 Latency: raw edge to sw_o update SHALL be 2 (sync) + DEBOUNCE_CNT + 1 cycles for a clean edge.
REQ-024 Counters SHALL be sized by $clog2 of their limit and SHALL never wrap.

Reset
REQ-025 While rst is high: sw_o=0, mode_chg=0, key_lvl=0, all FSMs IDLE, all counters and flags 0, synchronizer flops at released (1).
REQ-026 A key held through rst deassertion SHALL be debounced from IDLE as a fresh press.
REQ-027 Asserting rst mid-debounce or mid-long-press SHALL abort the event with no mode change after release of rst.

Structure
REQ-028 The debounce FSM state encoding and the default constants SHALL reside in a shared package.
REQ-029 The synchronizer and debounce FSM SHALL be one sub-module, key_debounce, instantiated once per key.
REQ-030 Mode register, long-press logic and arbitration SHALL live in key_mode_sel top level.

Verification (DEBOUNCE_CNT=4, LONG_PRESS_CNT=20, MODE_MAX=5)
REQ-031 Clean next press of 10 cycles then release -> sw_o 0->1 with one mode_chg pulse, key_lvl[0] high during hold.
REQ-032 Next press with 2-cycle glitches (shorter than 4) -> key_lvl stays 0, sw_o unchanged, no mode_chg.
REQ-033 sw_o=5, one next press/release -> sw_o=0; sw_o=0, one prev press -> sw_o=5.
REQ-034 sw_o=3, next held 30 cycles then released -> sw_o=0 once at hold count 20, no increment at release, exactly one mode_chg.
REQ-035 Next release pulse and prev press pulse in the same cycle at sw_o=2 -> sw_o stays 2, mode_chg stays 0.
REQ-036 rst asserted during PRESS_CHK at sw_o=4 -> sw_o=0, outputs zero; key still held after rst -> debounced afresh, no change until release.
